ucdp_sfifo: RTL and testbench

UCDP_SFIFO -- requirements
Module: ucdp_sfifo

---
 rtl/ucdp_sfifo_pkg.sv | 15 +
 rtl/ucdp_sfifo_mem.sv | 25 ++
 rtl/ucdp_sfifo.sv | 135 +++++++++++++
 tb/tb_ucdp_sfifo.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ucdp_sfifo_pkg.sv
// Shared types for the synchronous FIFO: decoded per-cycle operation.
package ucdp_sfifo_pkg;

    typedef enum logic [1:0] {
        OpIdle = 2'b00,
        OpWr   = 2'b01,
        OpRd   = 2'b10,
        OpBoth = 2'b11
    } sfifo_op_e;

    function automatic sfifo_op_e decode_op(input logic wr_acc, input logic rd_acc);
        return sfifo_op_e'({rd_acc, wr_acc});
    endfunction

endpackage

// File: rtl/ucdp_sfifo_mem.sv
// FIFO storage array: one clocked write port, one asynchronous read port, no reset.
module ucdp_sfifo_mem #(
    parameter int unsigned dwidth_p  = 8,
    parameter int unsigned depth_p   = 8,
    parameter int unsigned awidth_p  = 3
) (
    input  logic                clk_i,
    input  logic                wr_ena_i,
    input  logic [awidth_p-1:0] wr_addr_i,
    input  logic [dwidth_p-1:0] wr_data_i,
    input  logic [awidth_p-1:0] rd_addr_i,
    output logic [dwidth_p-1:0] rd_data_o
);

    logic [dwidth_p-1:0] mem_q [depth_p];

    always_ff @(posedge clk_i) begin
        if (wr_ena_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/ucdp_sfifo.sv
// Synchronous show-ahead FIFO with registered status flags and sticky overflow/underflow.
module ucdp_sfifo
    import ucdp_sfifo_pkg::*;
#(
    parameter int unsigned dwidth_p       = 8,
    parameter int unsigned depth_p        = 8,
    parameter int unsigned almfull_thr_p  = depth_p - 1,
    parameter int unsigned almempty_thr_p = 1,
    localparam int unsigned lvlwidth_p    = $clog2(depth_p + 1)
) (
    input  logic                  main_clk_i,
    input  logic                  main_rst_an_i,
    input  logic                  flush_i,
    input  logic                  wr_ena_i,
    input  logic [dwidth_p-1:0]   wr_data_i,
    output logic                  wr_full_o,
    output logic                  wr_almfull_o,
    input  logic                  rd_ena_i,
    output logic [dwidth_p-1:0]   rd_data_o,
    output logic                  rd_empty_o,
    output logic                  rd_almempty_o,
    output logic [lvlwidth_p-1:0] level_o,
    output logic                  ovf_o,
    output logic                  udf_o
);

    localparam int unsigned ptrwidth_p = $clog2(depth_p);

    localparam logic [ptrwidth_p-1:0] ptr_max_p  = ptrwidth_p'(depth_p - 1);
    localparam logic [lvlwidth_p-1:0] lvl_full_p = lvlwidth_p'(depth_p);
    localparam logic [lvlwidth_p-1:0] lvl_afull_p = lvlwidth_p'(almfull_thr_p);
    localparam logic [lvlwidth_p-1:0] lvl_aempty_p = lvlwidth_p'(almempty_thr_p);

    if (depth_p < 2 || dwidth_p < 1 || almempty_thr_p >= almfull_thr_p ||
        almfull_thr_p > depth_p) begin : g_param_err
        $error("ucdp_sfifo: invalid parameters (need depth>=2, 0<=almempty<almfull<=depth)");
    end

    logic [ptrwidth_p-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptrwidth_p-1:0] rd_ptr_q, rd_ptr_d;
    logic [lvlwidth_p-1:0] level_q, level_d;
    logic                  full_q, empty_q, almfull_q, almempty_q;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic                  wr_acc, rd_acc, mem_we;
    sfifo_op_e             op;

    function automatic logic [ptrwidth_p-1:0] inc_ptr(input logic [ptrwidth_p-1:0] ptr);
        return (ptr == ptr_max_p) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        wr_acc   = wr_ena_i & ~full_q;
        rd_acc   = rd_ena_i & ~empty_q;
        op       = decode_op(wr_acc, rd_acc);
        level_d  = level_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        // Errors flag the attempt, even when a simultaneous opposite request is accepted.
        ovf_d    = ovf_q | (wr_ena_i & full_q);
        udf_d    = udf_q | (rd_ena_i & empty_q);

        unique case (op)
            OpWr: begin
                level_d  = level_q + 1'b1;
                wr_ptr_d = inc_ptr(wr_ptr_q);
            end
            OpRd: begin
                level_d  = level_q - 1'b1;
                rd_ptr_d = inc_ptr(rd_ptr_q);
            end
            OpBoth: begin
                wr_ptr_d = inc_ptr(wr_ptr_q);
                rd_ptr_d = inc_ptr(rd_ptr_q);
            end
            default: ;
        endcase

        if (flush_i) begin
            level_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end
    end

    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            almfull_q  <= 1'b0;
            almempty_q <= 1'b1;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= (level_d == lvl_full_p);
            empty_q    <= (level_d == '0);
            almfull_q  <= (level_d >= lvl_afull_p);
            almempty_q <= (level_d <= lvl_aempty_p);
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    // Flushed writes must not land in storage either.
    assign mem_we = wr_acc & ~flush_i;

    ucdp_sfifo_mem #(
        .dwidth_p (dwidth_p),
        .depth_p  (depth_p),
        .awidth_p (ptrwidth_p)
    ) u_mem (
        .clk_i     (main_clk_i),
        .wr_ena_i  (mem_we),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_data_i),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data_o)
    );

    assign wr_full_o     = full_q;
    assign wr_almfull_o  = almfull_q;
    assign rd_empty_o    = empty_q;
    assign rd_almempty_o = almempty_q;
    assign level_o       = level_q;
    assign ovf_o         = ovf_q;
    assign udf_o         = udf_q;

endmodule

// File: tb/tb_ucdp_sfifo.sv
// Bench for ucdp_sfifo (width 8, depth 5): directed vector table, corner sequences, random vs queue model.
module tb_ucdp_sfifo;

    localparam int unsigned Dw = 8;
    localparam int unsigned Dp = 5;
    localparam int unsigned Af = 4;
    localparam int unsigned Ae = 1;

    logic          clk;
    logic          rst_an;
    logic          flush;
    logic          wr_ena;
    logic [Dw-1:0] wr_data;
    logic          rd_ena;
    logic [Dw-1:0] rd_data;
    logic          wr_full, wr_almfull, rd_empty, rd_almempty, ovf, udf;
    logic [2:0]    level;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: a plain queue plus two sticky bits.
    logic [Dw-1:0] mq[$];
    logic          m_ovf, m_udf;

    ucdp_sfifo #(
        .dwidth_p       (Dw),
        .depth_p        (Dp),
        .almfull_thr_p  (Af),
        .almempty_thr_p (Ae)
    ) dut (
        .main_clk_i    (clk),
        .main_rst_an_i (rst_an),
        .flush_i       (flush),
        .wr_ena_i      (wr_ena),
        .wr_data_i     (wr_data),
        .wr_full_o     (wr_full),
        .wr_almfull_o  (wr_almfull),
        .rd_ena_i      (rd_ena),
        .rd_data_o     (rd_data),
        .rd_empty_o    (rd_empty),
        .rd_almempty_o (rd_almempty),
        .level_o       (level),
        .ovf_o         (ovf),
        .udf_o         (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic fl, input logic wr, input logic rd,
                              input logic [Dw-1:0] wd);
        int sz;
        sz = mq.size();
        if (fl) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (wr && sz == Dp) m_ovf = 1'b1;
            if (rd && sz == 0)  m_udf = 1'b1;
            if (rd && sz > 0)   void'(mq.pop_front());
            if (wr && sz < Dp)  mq.push_back(wd);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // Drive one cycle of requests; returns at posedge+1 with inputs idle.
    task automatic apply(input logic fl, input logic wr, input logic rd, input logic [Dw-1:0] wd);
        flush   = fl;
        wr_ena  = wr;
        rd_ena  = rd;
        wr_data = wd;
        @(posedge clk);
        model_step(fl, wr, rd, wd);
        #1;
        flush  = 1'b0;
        wr_ena = 1'b0;
        rd_ena = 1'b0;
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = mq.size();
        cmp({tag, ".level"},    int'(level),       sz);
        cmp({tag, ".empty"},    int'(rd_empty),    int'(sz == 0));
        cmp({tag, ".full"},     int'(wr_full),     int'(sz == Dp));
        cmp({tag, ".almfull"},  int'(wr_almfull),  int'(sz >= Af));
        cmp({tag, ".almempty"}, int'(rd_almempty), int'(sz <= Ae));
        cmp({tag, ".ovf"},      int'(ovf),         int'(m_ovf));
        cmp({tag, ".udf"},      int'(udf),         int'(m_udf));
        if (sz > 0) cmp({tag, ".data"}, int'(rd_data), int'(mq[0]));
    endtask

    task automatic check_reset_vals(input string tag);
        cmp({tag, ".level"},    int'(level),       0);
        cmp({tag, ".empty"},    int'(rd_empty),    1);
        cmp({tag, ".almempty"}, int'(rd_almempty), 1);
        cmp({tag, ".full"},     int'(wr_full),     0);
        cmp({tag, ".almfull"},  int'(wr_almfull),  0);
        cmp({tag, ".ovf"},      int'(ovf),         0);
        cmp({tag, ".udf"},      int'(udf),         0);
    endtask

    typedef struct {
        logic          fl;
        logic          wr;
        logic          rd;
        logic [Dw-1:0] wd;
        int            lvl;
        logic          e, f, af, ae, ov, ud;
        logic [Dw-1:0] data;
    } vec_t;

    vec_t vecs[14];

    initial begin
        //        fl    wr    rd    wd     lvl e     f     af    ae    ovf   udf   data
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'hA1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA1};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h01, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h02, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h03, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h04, 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h05, 5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h66, 5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'h77, 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h02};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 8'h55, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 8'h10, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};

        rst_an  = 1'b0;
        flush   = 1'b0;
        wr_ena  = 1'b0;
        rd_ena  = 1'b0;
        wr_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_an = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            apply(vecs[i].fl, vecs[i].wr, vecs[i].rd, vecs[i].wd);
            cmp({t, ".level"},    int'(level),       vecs[i].lvl);
            cmp({t, ".empty"},    int'(rd_empty),    int'(vecs[i].e));
            cmp({t, ".full"},     int'(wr_full),     int'(vecs[i].f));
            cmp({t, ".almfull"},  int'(wr_almfull),  int'(vecs[i].af));
            cmp({t, ".almempty"}, int'(rd_almempty), int'(vecs[i].ae));
            cmp({t, ".ovf"},      int'(ovf),         int'(vecs[i].ov));
            cmp({t, ".udf"},      int'(udf),         int'(vecs[i].ud));
            if (!vecs[i].e) cmp({t, ".data"}, int'(rd_data), int'(vecs[i].data));
        end

        // Streaming at level 3 across several pointer wraps; order and level must hold.
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 1'b0, 8'(8'hB0 + i));
        check_model("prefill");
        for (int i = 0; i < 12; i++) begin
            logic [Dw-1:0] exp_head;
            exp_head = 8'(8'hB0 + i);
            cmp($sformatf("stream%0d.head", i), int'(rd_data), int'(exp_head));
            apply(1'b0, 1'b1, 1'b1, 8'(8'hB3 + i));
            cmp($sformatf("stream%0d.level", i), int'(level), 3);
            check_model($sformatf("stream%0d", i));
        end

        // Asynchronous reset between edges with level 3.
        #3;
        rst_an = 1'b0;
        #1;
        model_reset();
        check_reset_vals("async_rst");
        #2;
        rst_an = 1'b1;
        apply(1'b0, 1'b1, 1'b0, 8'hC3);
        cmp("post_rst.data", int'(rd_data), 8'hC3);
        check_model("post_rst");

        // Random traffic with alternating write-heavy / read-heavy phases.
        for (int i = 0; i < 400; i++) begin
            logic fl, wr, rd;
            int   wp;
            wp = ((i / 40) % 2 == 0) ? 70 : 30;
            fl = ($urandom_range(0, 59) == 0);
            wr = ($urandom_range(0, 99) < wp);
            rd = ($urandom_range(0, 99) < (100 - wp));
            apply(fl, wr, rd, 8'($urandom));
            check_model($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
